core_wakeup_seq: RTL and testbench



---
 rtl/core_wakeup_pkg.sv | 17 +
 rtl/core_wakeup_hart.sv | 126 ++++++++++++
 rtl/core_wakeup_seq.sv | 73 +++++++
 tb/tb_core_wakeup_seq.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_wakeup_pkg.sv
// Shared types and NoC wake-packet decode constants for the per-hart
// wakeup / reset-sequencing controller.
package core_wakeup_pkg;

    typedef enum logic [1:0] {
        ST_INIT      = 2'd0,
        ST_WAIT_WAKE = 2'd1,
        ST_RELEASE   = 2'd2,
        ST_RUN       = 2'd3
    } wake_state_e;

    localparam logic [1:0]  WakeTypeField = 2'b01;
    localparam logic [5:0]  WakePwrOn     = 6'h01;
    localparam logic [5:0]  WakeHartRst   = 6'h02;
    localparam int unsigned WakeDataWidth = 18;

endpackage

// File: rtl/core_wakeup_hart.sv
// One hart's wake FSM, reset stretch, wake-packet decode and gated
// interrupt synchronisers.
module core_wakeup_hart
    import core_wakeup_pkg::*;
#(
    parameter int unsigned NrIrq      = 2,
    parameter int unsigned WakeMode   = 2,
    parameter int unsigned RstStretch = 4,
    parameter int unsigned SyncStages = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cnt_done_i,
    input  logic                     wake_override_i,
    input  logic                     rtrn_val_i,
    input  logic                     rtrn_int_i,
    input  logic [WakeDataWidth-1:0] rtrn_data_i,
    input  logic [NrIrq-1:0]         irq_i,
    input  logic                     ipi_i,
    input  logic                     time_irq_i,
    input  logic                     debug_req_i,
    input  logic                     l15_val_i,
    output logic                     l15_val_o,
    output logic                     core_rst_no,
    output logic [NrIrq-1:0]         irq_o,
    output logic                     ipi_o,
    output logic                     time_irq_o,
    output logic                     debug_req_o,
    output logic [1:0]               state_o
);

    localparam int unsigned SyncW    = NrIrq + 3;
    localparam int unsigned StretchW = (RstStretch > 1) ? $clog2(RstStretch) : 1;
    localparam logic [StretchW-1:0] StretchLoad = StretchW'(RstStretch - 1);

    wake_state_e                     state_q, state_d;
    logic                            wake_seen_q, wake_seen_d;
    logic [StretchW-1:0]             stretch_q, stretch_d;
    logic                            core_rst_q, core_rst_d;
    logic [SyncStages-1:0][SyncW-1:0] sync_q;

    logic             ctrl_pkt, wake_pkt, rst_pkt, wake_eff, running;
    logic [SyncW-1:0] sync_in, sync_out;
    logic             unused_data_bits;

    assign ctrl_pkt = rtrn_val_i & rtrn_int_i & (rtrn_data_i[17:16] == WakeTypeField);
    assign wake_pkt = ctrl_pkt & (rtrn_data_i[5:0] == WakePwrOn);
    assign rst_pkt  = ctrl_pkt & (rtrn_data_i[5:0] == WakeHartRst);
    assign wake_eff = wake_seen_q | wake_override_i;
    assign running  = (state_q == ST_RUN);
    assign unused_data_bits = ^rtrn_data_i[15:6];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d     = state_q;
        stretch_d   = stretch_q;
        wake_seen_d = wake_seen_q | (wake_pkt & ~running);
        case (state_q)
            ST_INIT: begin
                if (WakeMode == 0) begin
                    if (cnt_done_i) begin
                        state_d   = ST_RELEASE;
                        stretch_d = StretchLoad;
                    end
                end else if (cnt_done_i || (WakeMode == 1)) begin
                    state_d = ST_WAIT_WAKE;
                end
            end
            ST_WAIT_WAKE: begin
                if (wake_eff || wake_pkt) begin
                    state_d   = ST_RELEASE;
                    stretch_d = StretchLoad;
                end
            end
            ST_RELEASE: begin
                if (stretch_q == '0) state_d = ST_RUN;
                else                 stretch_d = stretch_q - StretchW'(1);
            end
            ST_RUN: begin
                // Hart re-reset: reload so the core sees a full-length reset pulse.
                if (rst_pkt) begin
                    state_d   = ST_RELEASE;
                    stretch_d = StretchLoad;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    assign core_rst_d = (state_d == ST_RUN);
    assign sync_in    = {debug_req_i, time_irq_i, ipi_i, irq_i};

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_INIT;
            wake_seen_q <= 1'b0;
            stretch_q   <= '0;
            core_rst_q  <= 1'b0;
            sync_q      <= '0;
        end else begin
            state_q     <= state_d;
            wake_seen_q <= wake_seen_d;
            stretch_q   <= stretch_d;
            core_rst_q  <= core_rst_d;
            // Chains are flushed whenever the hart is not running.
            if (running) begin
                sync_q[0] <= sync_in;
                for (int i = 1; i < int'(SyncStages); i++) sync_q[i] <= sync_q[i-1];
            end else begin
                sync_q <= '0;
            end
        end
    end

    assign sync_out    = sync_q[SyncStages-1] & {SyncW{running}};
    assign irq_o       = sync_out[NrIrq-1:0];
    assign ipi_o       = sync_out[NrIrq];
    assign time_irq_o  = sync_out[NrIrq+1];
    assign debug_req_o = sync_out[NrIrq+2];
    assign l15_val_o   = l15_val_i & running;
    assign core_rst_no = core_rst_q;
    assign state_o     = state_q;

endmodule

// File: rtl/core_wakeup_seq.sv
// Multi-hart wakeup controller: shared SRAM-init counter plus one
// independent wake/reset sequencer per hart.
module core_wakeup_seq
    import core_wakeup_pkg::*;
#(
    parameter int unsigned NrHarts      = 1,
    parameter int unsigned NrIrq        = 2,
    parameter int unsigned WakeMode     = 2,
    parameter int unsigned WakeCntWidth = 16,
    parameter int unsigned RstStretch   = 4,
    parameter int unsigned SyncStages   = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               wake_override_i,
    input  logic [NrHarts-1:0]                 rtrn_val_i,
    input  logic [NrHarts-1:0]                 rtrn_int_i,
    input  logic [NrHarts*WakeDataWidth-1:0]   rtrn_data_i,
    input  logic [NrHarts*NrIrq-1:0]           irq_i,
    input  logic [NrHarts-1:0]                 ipi_i,
    input  logic [NrHarts-1:0]                 time_irq_i,
    input  logic [NrHarts-1:0]                 debug_req_i,
    input  logic [NrHarts-1:0]                 l15_val_i,
    output logic [NrHarts-1:0]                 l15_val_o,
    output logic [NrHarts-1:0]                 core_rst_no,
    output logic [NrHarts*NrIrq-1:0]           irq_o,
    output logic [NrHarts-1:0]                 ipi_o,
    output logic [NrHarts-1:0]                 time_irq_o,
    output logic [NrHarts-1:0]                 debug_req_o,
    output logic [NrHarts*2-1:0]               state_o
);

    logic [WakeCntWidth-1:0] cnt_q;
    logic                    cnt_done;

    // Init counter saturates once its MSB is set.
    assign cnt_done = cnt_q[WakeCntWidth-1];

    always_ff @(posedge clk_i) begin
        if (rst_i)          cnt_q <= '0;
        else if (!cnt_done) cnt_q <= cnt_q + WakeCntWidth'(1);
    end

    for (genvar h = 0; h < NrHarts; h++) begin : g_hart
        core_wakeup_hart #(
            .NrIrq      (NrIrq),
            .WakeMode   (WakeMode),
            .RstStretch (RstStretch),
            .SyncStages (SyncStages)
        ) u_hart (
            .clk_i           (clk_i),
            .rst_i           (rst_i),
            .cnt_done_i      (cnt_done),
            .wake_override_i (wake_override_i),
            .rtrn_val_i      (rtrn_val_i[h]),
            .rtrn_int_i      (rtrn_int_i[h]),
            .rtrn_data_i     (rtrn_data_i[h*WakeDataWidth +: WakeDataWidth]),
            .irq_i           (irq_i[h*NrIrq +: NrIrq]),
            .ipi_i           (ipi_i[h]),
            .time_irq_i      (time_irq_i[h]),
            .debug_req_i     (debug_req_i[h]),
            .l15_val_i       (l15_val_i[h]),
            .l15_val_o       (l15_val_o[h]),
            .core_rst_no     (core_rst_no[h]),
            .irq_o           (irq_o[h*NrIrq +: NrIrq]),
            .ipi_o           (ipi_o[h]),
            .time_irq_o      (time_irq_o[h]),
            .debug_req_o     (debug_req_o[h]),
            .state_o         (state_o[h*2 +: 2])
        );
    end

endmodule

// File: tb/tb_core_wakeup_seq.sv
// Bench for core_wakeup_seq: three instances (wake modes 0/1/2, two harts each)
// driven by shared stimulus and checked against an edge-timeline model.
module tb_core_wakeup_seq;

    localparam int NDUT = 3;
    localparam int NH   = 2;
    localparam int W    = 4;
    localparam int STR  = 4;
    localparam int CntDoneEdge = 1 << (W - 1);
    localparam logic [1:0] S_INIT = 2'd0, S_WAIT = 2'd1, S_REL = 2'd2, S_RUN = 2'd3;
    localparam logic [17:0] PKT_WAKE = 18'h10001, PKT_RST = 18'h10002, PKT_BADTYPE = 18'h20001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, override;
    logic [1:0]  rval, rint, ipi, tirq, dbg, l15;
    logic [35:0] rdata;
    logic [3:0]  irq;

    logic [1:0] l15_o [NDUT];
    logic [1:0] crst_o[NDUT];
    logic [3:0] irq_o [NDUT];
    logic [1:0] ipi_o [NDUT];
    logic [1:0] tirq_o[NDUT];
    logic [1:0] dbg_o [NDUT];
    logic [3:0] st_o  [NDUT];

    for (genvar d = 0; d < NDUT; d++) begin : g_dut
        core_wakeup_seq #(
            .NrHarts(NH), .NrIrq(2), .WakeMode(d), .WakeCntWidth(W),
            .RstStretch(STR), .SyncStages(2)
        ) u_dut (
            .clk_i(clk), .rst_i(rst), .wake_override_i(override),
            .rtrn_val_i(rval), .rtrn_int_i(rint), .rtrn_data_i(rdata),
            .irq_i(irq), .ipi_i(ipi), .time_irq_i(tirq), .debug_req_i(dbg),
            .l15_val_i(l15), .l15_val_o(l15_o[d]), .core_rst_no(crst_o[d]),
            .irq_o(irq_o[d]), .ipi_o(ipi_o[d]), .time_irq_o(tirq_o[d]),
            .debug_req_o(dbg_o[d]), .state_o(st_o[d])
        );
    end

    int tests_run = 0;
    int tests_failed = 0;

    // Timeline model: for each hart, the edge numbers at which RELEASE and RUN
    // begin, derived from the wake rules; n counts edges since reset released.
    int         n;
    int         rel_e [NDUT][NH];
    int         run_e [NDUT][NH];
    int         wake_e[NDUT][NH];
    logic [1:0] exp_st[NDUT][NH];
    logic       run_pp[NDUT][NH];
    logic [4:0] exp_sync[NDUT][NH];
    logic [4:0] in_p1[NH];

    function automatic int wait_edge(int d);
        if (d == 1) return 1;
        if (d == 2) return CntDoneEdge + 1;
        return 1 << 30;
    endfunction

    function automatic logic [1:0] state_at(int d, int h, int e);
        if (run_e[d][h] >= 0 && e >= run_e[d][h]) return S_RUN;
        if (rel_e[d][h] >= 0 && e >= rel_e[d][h]) return S_REL;
        if (e >= wait_edge(d)) return S_WAIT;
        return S_INIT;
    endfunction

    function automatic bit is_pkt(int h, logic [5:0] sub);
        return rval[h] && rint[h] && (rdata[h*18+16 +: 2] == 2'b01) && (rdata[h*18 +: 6] == sub);
    endfunction

    task automatic model_reset();
        n = 0;
        for (int d = 0; d < NDUT; d++) begin
            for (int h = 0; h < NH; h++) begin
                wake_e[d][h]   = -1;
                rel_e[d][h]    = (d == 0) ? CntDoneEdge + 1 : -1;
                run_e[d][h]    = (d == 0) ? CntDoneEdge + 1 + STR : -1;
                exp_st[d][h]   = S_INIT;
                run_pp[d][h]   = 1'b0;
                exp_sync[d][h] = '0;
            end
        end
    endtask

    // One clock edge: advance the model with the inputs sampled at this edge.
    task automatic step();
        logic [1:0] prev, cur;
        int wl;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            n++;
            for (int d = 0; d < NDUT; d++) begin
                for (int h = 0; h < NH; h++) begin
                    prev = exp_st[d][h];
                    if (prev == S_RUN && is_pkt(h, 6'h02)) begin
                        rel_e[d][h] = n;
                        run_e[d][h] = n + STR;
                    end else if (prev != S_RUN && wake_e[d][h] < 0 &&
                                 (is_pkt(h, 6'h01) || override)) begin
                        wake_e[d][h] = n;
                    end
                    if (d != 0 && rel_e[d][h] < 0 && wake_e[d][h] >= 0) begin
                        wl = wait_edge(d) + 1;
                        rel_e[d][h] = (wake_e[d][h] > wl) ? wake_e[d][h] : wl;
                        run_e[d][h] = rel_e[d][h] + STR;
                    end
                    cur = state_at(d, h, n);
                    exp_sync[d][h] = (cur == S_RUN && prev == S_RUN && run_pp[d][h]) ? in_p1[h] : '0;
                    run_pp[d][h] = (prev == S_RUN);
                    exp_st[d][h] = cur;
                end
            end
        end
        for (int h = 0; h < NH; h++) in_p1[h] = {dbg[h], tirq[h], ipi[h], irq[h*2 +: 2]};
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; override = 1'b0; rval = '0; rint = '0; rdata = '0;
        irq = '0; ipi = '0; tirq = '0; dbg = '0; l15 = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        l15 = 2'b11; irq = 4'hf; ipi = 2'b11; tirq = 2'b11; dbg = 2'b11;
        rst = 1'b1;
        step();
        step();
        for (int d = 0; d < NDUT; d++) begin
            tests_run++;
            if (st_o[d] !== 4'b0000) begin
                tests_failed++; $display("FAIL reset_state dut%0d: got %b want 0000", d, st_o[d]);
            end
            tests_run++;
            if (crst_o[d] !== 2'b00) begin
                tests_failed++; $display("FAIL reset_core_rst dut%0d: got %b want 00", d, crst_o[d]);
            end
            tests_run++;
            if ({irq_o[d], ipi_o[d], tirq_o[d], dbg_o[d]} !== 10'h0) begin
                tests_failed++;
                $display("FAIL reset_irq dut%0d: got %h want 0", d, {irq_o[d], ipi_o[d], tirq_o[d], dbg_o[d]});
            end
            tests_run++;
            if (l15_o[d] !== 2'b00) begin
                tests_failed++; $display("FAIL reset_l15 dut%0d: got %b want 00", d, l15_o[d]);
            end
        end
        tests_run++;
        if (g_dut[0].u_dut.cnt_q !== 4'd0) begin
            tests_failed++; $display("FAIL reset_cnt: got %0d want 0", g_dut[0].u_dut.cnt_q);
        end
        idle();
    endtask

    task automatic test_mode0_latency();
        logic [3:0] w_st;
        logic [1:0] w_on;
        do_reset();
        l15 = 2'b11;
        for (int k = 1; k <= 14; k++) begin
            step();
            w_st = (k < 9) ? 4'b0000 : (k < 13) ? 4'b1010 : 4'b1111;
            w_on = (k >= 13) ? 2'b11 : 2'b00;
            tests_run++;
            if (st_o[0] !== w_st) begin
                tests_failed++; $display("FAIL m0_state edge%0d: got %b want %b", k, st_o[0], w_st);
            end
            tests_run++;
            if (crst_o[0] !== w_on) begin
                tests_failed++; $display("FAIL m0_core_rst edge%0d: got %b want %b", k, crst_o[0], w_on);
            end
            tests_run++;
            if (l15_o[0] !== w_on) begin
                tests_failed++; $display("FAIL m0_l15 edge%0d: got %b want %b", k, l15_o[0], w_on);
            end
        end
        for (int d = 1; d < NDUT; d++) begin
            tests_run++;
            if (st_o[d] !== 4'b0101) begin
                tests_failed++; $display("FAIL nowake_wait dut%0d: got %b want 0101", d, st_o[d]);
            end
        end
        l15 = 2'b01;
        #1;
        tests_run++;
        if (l15_o[0] !== 2'b01) begin
            tests_failed++; $display("FAIL m0_l15_follow: got %b want 01", l15_o[0]);
        end
        idle();
    endtask

    task automatic test_mode2_wake();
        logic [1:0] h0, h1;
        do_reset();
        for (int k = 1; k <= 15; k++) begin
            if (k == 1 || k == 3) begin
                rval = 2'b11; rint = 2'b11;
                rdata = {PKT_BADTYPE, (k == 3) ? PKT_WAKE : PKT_BADTYPE};
            end
            step();
            rval = '0; rint = '0; rdata = '0;
            h0 = (k < 9) ? S_INIT : (k == 9) ? S_WAIT : (k < 14) ? S_REL : S_RUN;
            h1 = (k < 9) ? S_INIT : S_WAIT;
            tests_run++;
            if (st_o[2] !== {h1, h0}) begin
                tests_failed++; $display("FAIL m2_state edge%0d: got %b want %b", k, st_o[2], {h1, h0});
            end
            tests_run++;
            if (crst_o[2] !== {1'b0, k >= 14}) begin
                tests_failed++; $display("FAIL m2_core_rst edge%0d: got %b want %b", k, crst_o[2], {1'b0, k >= 14});
            end
        end
    endtask

    task automatic test_mode1_override();
        logic [1:0] h0, h1;
        do_reset();
        step();
        tests_run++;
        if (st_o[1] !== 4'b0101) begin
            tests_failed++; $display("FAIL m1_wait edge1: got %b want 0101", st_o[1]);
        end
        for (int k = 2; k <= 31; k++) begin
            if (k == 2) begin
                rval = 2'b10; rint = 2'b10; rdata = {PKT_WAKE, 18'h0};
            end
            if (k == 26) override = 1'b1;
            step();
            rval = '0; rint = '0; rdata = '0;
            h1 = (k < 6) ? S_REL : S_RUN;
            h0 = (k < 26) ? S_WAIT : (k < 30) ? S_REL : S_RUN;
            tests_run++;
            if (st_o[1] !== {h1, h0}) begin
                tests_failed++; $display("FAIL m1_state edge%0d: got %b want %b", k, st_o[1], {h1, h0});
            end
            tests_run++;
            if (crst_o[1] !== {k >= 6, k >= 30}) begin
                tests_failed++; $display("FAIL m1_core_rst edge%0d: got %b want %b", k, crst_o[1], {k >= 6, k >= 30});
            end
        end
        idle();
    endtask

    task automatic test_irq_rereset();
        logic [3:0] w_irq;
        logic [1:0] h0;
        do_reset();
        for (int k = 1; k <= 13; k++) step();
        irq = 4'b0011; ipi = 2'b10;
        for (int k = 14; k <= 22; k++) begin
            if (k == 16) begin
                rval = 2'b01; rint = 2'b01; rdata = {18'h0, PKT_RST};
            end
            step();
            rval = '0; rint = '0; rdata = '0;
            w_irq = (k == 15 || k >= 22) ? 4'b0011 : 4'b0000;
            h0 = (k < 16 || k >= 20) ? S_RUN : S_REL;
            tests_run++;
            if (irq_o[0] !== w_irq) begin
                tests_failed++; $display("FAIL rr_irq edge%0d: got %b want %b", k, irq_o[0], w_irq);
            end
            tests_run++;
            if (st_o[0] !== {S_RUN, h0}) begin
                tests_failed++; $display("FAIL rr_state edge%0d: got %b want %b", k, st_o[0], {S_RUN, h0});
            end
            tests_run++;
            if (crst_o[0] !== {1'b1, h0 == S_RUN}) begin
                tests_failed++; $display("FAIL rr_core_rst edge%0d: got %b want %b", k, crst_o[0], {1'b1, h0 == S_RUN});
            end
            tests_run++;
            if (ipi_o[0] !== ((k >= 15) ? 2'b10 : 2'b00)) begin
                tests_failed++; $display("FAIL rr_ipi_other_hart edge%0d: got %b", k, ipi_o[0]);
            end
        end
        idle();
    endtask

    task automatic test_reset_midop();
        do_reset();
        irq = 4'hf; ipi = 2'b11; tirq = 2'b11; dbg = 2'b11; l15 = 2'b11;
        for (int k = 1; k <= 10; k++) step();
        for (int pass = 0; pass < 2; pass++) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
            for (int d = 0; d < NDUT; d++) begin
                tests_run++;
                if ({st_o[d], crst_o[d], l15_o[d], irq_o[d], ipi_o[d], tirq_o[d], dbg_o[d]} !== 18'h0) begin
                    tests_failed++;
                    $display("FAIL midop_reset pass%0d dut%0d: got %h want 0", pass, d,
                             {st_o[d], crst_o[d], l15_o[d], irq_o[d], ipi_o[d], tirq_o[d], dbg_o[d]});
                end
            end
            if (pass == 0) begin
                for (int k = 1; k <= 15; k++) begin
                    step();
                    if (k == 8 || k == 9) begin
                        tests_run++;
                        if (st_o[0] !== ((k == 8) ? 4'b0000 : 4'b1010)) begin
                            tests_failed++; $display("FAIL midop_restart edge%0d: got %b", k, st_o[0]);
                        end
                    end
                end
                tests_run++;
                if ({irq_o[0], ipi_o[0], tirq_o[0], dbg_o[0], crst_o[0]} !== 12'hfff) begin
                    tests_failed++;
                    $display("FAIL midop_run_irq: got %h want fff", {irq_o[0], ipi_o[0], tirq_o[0], dbg_o[0], crst_o[0]});
                end
            end
        end
        idle();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 1; k <= 13; k++) step();
        for (int k = 0; k < 50; k++) begin
            step();
            tests_run++;
            if (st_o[0] !== 4'b1111 || crst_o[0] !== 2'b11) begin
                tests_failed++; $display("FAIL sat_run cyc%0d: got st %b rst %b", k, st_o[0], crst_o[0]);
            end
        end
        tests_run++;
        if (g_dut[0].u_dut.cnt_q !== 4'd8) begin
            tests_failed++; $display("FAIL sat_cnt: got %0d want 8", g_dut[0].u_dut.cnt_q);
        end
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int c = 0; c < 700; c++) begin
            rst = ($urandom_range(0, 249) == 0);
            if (rst) override = 1'b0;
            else if (!override && $urandom_range(0, 149) == 0) override = 1'b1;
            for (int h = 0; h < NH; h++) begin
                r = $urandom_range(0, 39);
                rval[h] = (r < 4); rint[h] = 1'b1;
                if (r == 0)      rdata[h*18 +: 18] = PKT_WAKE;
                else if (r == 1) rdata[h*18 +: 18] = PKT_RST;
                else begin
                    rint[h] = 1'($urandom_range(0, 1));
                    rdata[h*18 +: 18] = {2'($urandom_range(0, 3)), 10'($urandom), 6'($urandom_range(0, 3))};
                end
            end
            irq = 4'($urandom); ipi = 2'($urandom); tirq = 2'($urandom);
            dbg = 2'($urandom); l15 = 2'($urandom);
            step();
            for (int d = 0; d < NDUT; d++) begin
                logic [3:0] w_st, w_irq;
                logic [1:0] w_run, w_ipi, w_tim, w_dbg;
                for (int h = 0; h < NH; h++) begin
                    w_st[h*2 +: 2]  = exp_st[d][h];
                    w_run[h]        = (exp_st[d][h] == S_RUN);
                    w_irq[h*2 +: 2] = exp_sync[d][h][1:0];
                    w_ipi[h]        = exp_sync[d][h][2];
                    w_tim[h]        = exp_sync[d][h][3];
                    w_dbg[h]        = exp_sync[d][h][4];
                end
                tests_run++;
                if (st_o[d] !== w_st) begin
                    tests_failed++; $display("FAIL rnd_state dut%0d cyc%0d: got %b want %b", d, c, st_o[d], w_st);
                end
                tests_run++;
                if (crst_o[d] !== w_run) begin
                    tests_failed++; $display("FAIL rnd_core_rst dut%0d cyc%0d: got %b want %b", d, c, crst_o[d], w_run);
                end
                tests_run++;
                if (l15_o[d] !== (l15 & w_run)) begin
                    tests_failed++; $display("FAIL rnd_l15 dut%0d cyc%0d: got %b want %b", d, c, l15_o[d], l15 & w_run);
                end
                tests_run++;
                if ({irq_o[d], ipi_o[d], tirq_o[d], dbg_o[d]} !== {w_irq, w_ipi, w_tim, w_dbg}) begin
                    tests_failed++;
                    $display("FAIL rnd_sync dut%0d cyc%0d: got %b want %b", d, c,
                             {irq_o[d], ipi_o[d], tirq_o[d], dbg_o[d]}, {w_irq, w_ipi, w_tim, w_dbg});
                end
            end
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_mode0_latency();
        test_mode2_wake();
        test_mode1_override();
        test_irq_rereset();
        test_reset_midop();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
